// File: rtl/fifo_rd_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_pkg
// Shared constants and helpers for the FIFO read-side stream adapter.
//   OCC_MAX    : depth of the output buffer (entries)
//   OCC_W      : width of the occupancy count (holds 0..OCC_MAX)
//   OCC_LIMIT  : OCC_MAX sized for the buffered + in-flight sum
//   slot_free(): issue permission derived from occupancy, in-flight and pop
// -----------------------------------------------------------------------------
package fifo_rd_pkg;

    localparam int OCC_MAX = 2;
    localparam int OCC_W   = 2;

    // One extra bit so that occ + infl never wraps before the compare.
    localparam logic [OCC_W:0] OCC_LIMIT = OCC_MAX[OCC_W:0];

    // A new read may be issued when the entries that will still be owned
    // after this cycle's pop (buffered + in flight - popped) leave room for
    // one more word. Crediting the pop is what lets a 2-entry buffer keep
    // up with one beat per cycle.
    function automatic logic slot_free(
        input logic [OCC_W-1:0] occ,
        input logic             infl,
        input logic             pop
    );
        logic [OCC_W:0] w_cnt;
        w_cnt = {1'b0, occ} + {{OCC_W{1'b0}}, infl} - {{OCC_W{1'b0}}, pop};
        return (w_cnt < OCC_LIMIT);
    endfunction

endpackage : fifo_rd_pkg

// File: rtl/fifo_rd_skid.sv
// -----------------------------------------------------------------------------
// fifo_rd_skid
// Two-entry circular output buffer with head/tail pointers and an occupancy
// count. Pushes append at the tail, pops retire the head, clear empties the
// buffer in one cycle. The head word is presented straight from the storage
// registers, so the output carries no combinational path from the push data.
//
// Ports
//   clk          : clock
//   srst_n       : synchronous active-low reset
//   i_push       : write i_push_data at the tail this cycle
//   i_push_data  : word to append
//   i_pop        : retire the head entry this cycle (ignored when empty)
//   i_clear      : discard all entries (wins over push; pointers rewind)
//   o_head_data  : oldest buffered word
//   o_valid      : buffer holds at least one entry
//   o_occ        : number of buffered entries (0..OCC_MAX)
// -----------------------------------------------------------------------------
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_head_data,
    output logic             o_valid,
    output logic [OCC_W-1:0] o_occ
);

    // Storage and pointers. With OCC_MAX = 2 each pointer is a single bit
    // that simply toggles on every advance.
    logic [WIDTH-1:0] r_mem [OCC_MAX];
    logic             r_head;
    logic             r_tail;
    logic [OCC_W-1:0] r_occ;

    logic             w_head_next;
    logic             w_tail_next;
    logic [OCC_W-1:0] w_occ_next;
    logic             w_push;
    logic             w_pop;

    // A pop against an empty buffer is meaningless; gate it locally so the
    // pointers can never run ahead of the data.
    assign w_pop  = i_pop & (r_occ != '0);
    assign w_push = i_push & ~i_clear;

    always_comb begin
        w_head_next = r_head;
        w_tail_next = r_tail;
        w_occ_next  = r_occ;
        if (i_clear) begin
            w_head_next = 1'b0;
            w_tail_next = 1'b0;
            w_occ_next  = '0;
        end else begin
            if (w_push) begin
                w_tail_next = ~r_tail;
            end
            if (w_pop) begin
                w_head_next = ~r_head;
            end
            // Simultaneous push and pop leaves the count unchanged.
            w_occ_next = r_occ + {{(OCC_W-1){1'b0}}, w_push}
                               - {{(OCC_W-1){1'b0}}, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            r_head <= 1'b0;
            r_tail <= 1'b0;
            r_occ  <= '0;
            for (int i = 0; i < OCC_MAX; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_head <= w_head_next;
            r_tail <= w_tail_next;
            r_occ  <= w_occ_next;
            if (w_push) begin
                r_mem[r_tail] <= i_push_data;
            end
        end
    end

    assign o_head_data = r_mem[r_head];
    assign o_valid     = (r_occ != '0);
    assign o_occ       = r_occ;

    // The issue logic upstream must never let a push land on a full buffer
    // without a matching pop.
    a_no_overflow : assert property (@(posedge clk) disable iff (!srst_n)
        !(w_push && !w_pop && (r_occ == OCC_MAX[OCC_W-1:0])));

endmodule : fifo_rd_skid

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Read-side consumer for a FIFO read port (rinc / rempty / rdata, with rdata
// registered one cycle after an accepted read). Turns that port into a
// valid/ready stream backed by a 2-entry buffer, sustaining one beat per
// cycle without ever overrunning the buffer or dropping a returning word.
// Everything runs on rclk.
//
// Ports
//   rclk      : read-domain clock
//   rrstn     : synchronous active-low reset
//   rempty    : FIFO empty flag
//   rinc      : read request to the FIFO
//   rdata     : FIFO read data, valid the cycle after an accepted read
//   m_valid   : output beat valid
//   m_ready   : downstream accept
//   m_data    : output beat data (head of the buffer)
//   flush     : one-cycle discard of buffered and in-flight data
//   occ       : buffered entries (0..2)
//   beat_cnt  : completed output handshakes, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             rclk,
    input  logic             rrstn,
    input  logic             rempty,
    output logic             rinc,
    input  logic [WIDTH-1:0] rdata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    input  logic             flush,
    output logic [1:0]       occ,
    output logic [CNT_W-1:0] beat_cnt
);

    // r_infl marks that a read was accepted last cycle, so rdata carries a
    // word that must be captured now.
    logic             r_infl;
    logic [CNT_W-1:0] r_beat_cnt;

    logic             w_pop;
    logic             w_issue;
    logic             w_push;
    logic             w_valid;
    logic [OCC_W-1:0] w_occ;
    logic [WIDTH-1:0] w_head_data;

    assign w_pop = w_valid & m_ready;

    // rrstn is part of the term so that no read reaches the FIFO during the
    // reset cycle; flush blocks issue so nothing new arrives behind it.
    assign w_issue = rrstn & ~flush & ~rempty & slot_free(w_occ, r_infl, w_pop);

    // A word returning during a flush is dropped instead of captured.
    assign w_push = r_infl & ~flush;

    always_ff @(posedge rclk) begin
        if (!rrstn) begin
            r_infl     <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_infl <= w_issue;
            // A handshake in the flush cycle still completed, so it counts.
            if (w_pop) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    fifo_rd_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk         (rclk),
        .srst_n      (rrstn),
        .i_push      (w_push),
        .i_push_data (rdata),
        .i_pop       (w_pop),
        .i_clear     (flush),
        .o_head_data (w_head_data),
        .o_valid     (w_valid),
        .o_occ       (w_occ)
    );

    assign rinc     = w_issue;
    assign m_valid  = w_valid;
    assign m_data   = w_head_data;
    assign occ      = w_occ;
    assign beat_cnt = r_beat_cnt;

endmodule : fifo_rd_stream
